// File: rtl/dbus_demux.sv
// dbus_demux: routes one data-bus initiator to RAM/peripheral/timer targets by address decode.
// Define DBUS_TIMEOUT_EN to force an error response after TIMEOUT_CYCLES spent in REQ+RESP.
module dbus_demux #(
    parameter logic [31:0] T0_BASE = 32'h0000_0000,
    parameter logic [31:0] T0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] T1_BASE = 32'h1000_0000,
    parameter logic [31:0] T1_MASK = 32'hFFFF_F000,
    parameter logic [31:0] T2_BASE = 32'h2000_0000,
    parameter logic [31:0] T2_MASK = 32'hFFFF_FF00,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  t_valid,
    input  logic [2:0]  t_ready,
    output logic [31:0] t_addr,
    output logic        t_we,
    output logic [31:0] t_wdata,
    output logic [3:0]  t_wstrb,
    input  logic [2:0]  t_rvalid,
    input  logic [95:0] t_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic we_q, we_d, err_q, err_d;
    logic [3:0] wstrb_q, wstrb_d;
    logic [2:0] hit;
    logic timeout;
`ifdef DBUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    assign hit = {(req_addr & T2_MASK) == T2_BASE,
                  (req_addr & T1_MASK) == T1_BASE,
                  (req_addr & T0_MASK) == T0_BASE};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DBUS_TIMEOUT_EN
        // counter is zero on REQ entry and counts every REQ/RESP cycle
        cnt_d   = (state_q == REQ || state_q == RESP) ? cnt_q + 16'd1 : 16'd0;
        timeout = (state_q == REQ || state_q == RESP) && cnt_q == 16'(TIMEOUT_CYCLES - 1);
`else
        timeout = TIMEOUT_CYCLES < 0;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                we_d    = req_we;
                wdata_d = req_wdata;
                wstrb_d = req_wstrb;
                sel_d   = hit[0] ? 2'd0 : hit[1] ? 2'd1 : 2'd2;
                state_d = (|hit) ? REQ : DONE;
                if (~|hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            REQ: if (timeout) begin
                state_d = DONE;
                rdata_d = '0;
                err_d   = 1'b1;
            end else if (t_ready[sel_q]) begin
                state_d = RESP;
            end
            RESP: if (timeout) begin
                state_d = DONE;
                rdata_d = '0;
                err_d   = 1'b1;
            end else if (t_rvalid[sel_q]) begin
                state_d = DONE;
                rdata_d = we_q ? 32'd0 : t_rdata[{sel_q, 5'd0} +: 32];
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DBUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == DONE;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign t_valid    = (state_q == REQ) ? 3'b001 << sel_q : 3'b000;
    assign t_addr     = addr_q;
    assign t_we       = we_q;
    assign t_wdata    = wdata_q;
    assign t_wstrb    = wstrb_q;
endmodule

// File: tb/tb_dbus_demux.sv
// tb_dbus_demux: vector table of single transactions plus hand-written multi-cycle sequences;
// responses are checked against a queue of expected {rdata, err, cycle} entries.
module tb_dbus_demux;
    logic clk, rst, req_valid, req_ready, req_we, resp_valid, resp_err, t_we;
    logic [31:0] req_addr, req_wdata, resp_rdata, t_addr, t_wdata;
    logic [3:0] req_wstrb, t_wstrb;
    logic [2:0] t_valid, t_ready, t_rvalid;
    logic [95:0] t_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdly;
        int          vdly;
        logic [31:0] trd;
        logic [2:0]  exp_tv;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int tests = 0, fails = 0, cyc = 0;

    dbus_demux dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .t_valid(t_valid), .t_ready(t_ready), .t_addr(t_addr), .t_we(t_we),
        .t_wdata(t_wdata), .t_wstrb(t_wstrb), .t_rvalid(t_rvalid), .t_rdata(t_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // advance one clock, then look at the outputs 1ns after the edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected resp_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp cycle", 32'(cyc), 32'(e.at));
            end
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [2:0] m;
        int tg;
        m  = v.exp_tv;
        tg = m[1] ? 1 : m[2] ? 2 : 0;
        check("req_ready idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        sb.push_back(exp_t'{v.exp_rdata, v.exp_err, cyc + 1 + ((m != 0) ? 2 + v.rdly + v.vdly : 0)});
        step();
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_we    = ~v.we;
        req_wdata = ~v.wdata;
        req_wstrb = ~v.wstrb;
        if (m == 3'b000) begin
            check("t_valid unmapped", 32'(t_valid), 32'd0);
            check("req_ready done", 32'(req_ready), 32'd0);
            step();
        end else begin
            for (int i = 0; i <= v.rdly; i++) begin
                check("t_valid req", 32'(t_valid), 32'(m));
                check("req_ready req", 32'(req_ready), 32'd0);
                if (i == 0) begin
                    check("t_addr", t_addr, v.addr);
                    check("t_we", 32'(t_we), 32'(v.we));
                    check("t_wdata", t_wdata, v.wdata);
                    check("t_wstrb", 32'(t_wstrb), 32'(v.wstrb));
                end
                t_rvalid = 3'b111;
                t_ready  = (i == v.rdly) ? m : ~m;
                step();
            end
            t_ready = 3'b111;
            for (int i = 0; i <= v.vdly; i++) begin
                check("t_valid resp", 32'(t_valid), 32'd0);
                t_rvalid = (i == v.vdly) ? m : ~m;
                t_rdata  = {3{32'hBAD0_BAD0}};
                if (i == v.vdly) t_rdata[tg*32 +: 32] = v.trd;
                step();
            end
            t_ready  = 3'b000;
            t_rvalid = 3'b000;
            step();
        end
    endtask

    initial begin
        logic [7:0] rr;
        int acc;
        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 3'b001, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{32'h1000_0004, 1'b1, 32'h1234_5678, 4'b0011, 2, 0, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0};
        vecs[2] = '{32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 3'b000, 32'h0, 1'b1};
        vecs[3] = '{32'h2000_00FC, 1'b0, 32'h5555_AAAA, 4'hF, 1, 2, 32'h0BAD_C0DE, 3'b100, 32'h0BAD_C0DE, 1'b0};
        vecs[4] = '{32'h0000_FFFC, 1'b0, 32'h0, 4'h1, 0, 1, 32'h1357_9BDF, 3'b001, 32'h1357_9BDF, 1'b0};
        vecs[5] = '{32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 3'b000, 32'h0, 1'b1};
        vecs[6] = '{32'h1000_0FFC, 1'b0, 32'h0, 4'hF, 1, 1, 32'h5A5A_5A5A, 3'b010, 32'h5A5A_5A5A, 1'b0};
        vecs[7] = '{32'h1000_1000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 3'b000, 32'h0, 1'b1};
        vecs[8] = '{32'h2000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 3'b000, 32'h0, 1'b1};
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_we = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        t_ready = '0;
        t_rvalid = '0;
        t_rdata = '0;
        step();
        step();
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset t_valid", 32'(t_valid), 32'd0);
        check("reset t_addr", t_addr, 32'd0);
        check("reset t_we", 32'(t_we), 32'd0);
        check("reset t_wdata", t_wdata, 32'd0);
        check("reset t_wstrb", 32'(t_wstrb), 32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[k]) run_txn(vecs[k]);
        check("hold resp_err", 32'(resp_err), 32'd1);
        check("hold resp_rdata", resp_rdata, 32'd0);

        // back-to-back reads to target 2 with req_valid held high
        req_valid = 1'b1;
        req_addr  = 32'h2000_0010;
        req_we    = 1'b0;
        t_ready   = 3'b100;
        t_rvalid  = 3'b100;
        t_rdata   = {32'h1111_1111, 64'h0};
        sb.push_back(exp_t'{32'h1111_1111, 1'b0, cyc + 3});
        sb.push_back(exp_t'{32'h2222_2222, 1'b0, cyc + 7});
        rr = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step();
            check("b2b req_ready", 32'(req_ready), 32'(rr[i]));
            if (i == 0) check("b2b t_valid", 32'(t_valid), 32'b100);
            if (i == 2) t_rdata = {32'h2222_2222, 64'h0};
            if (i == 4) req_valid = 1'b0;
        end
        t_ready  = 3'b000;
        t_rvalid = 3'b000;
        step();
        step();
        check("hold rdata b2b", resp_rdata, 32'h2222_2222);
        check("hold err b2b", 32'(resp_err), 32'd0);

`ifdef DBUS_TIMEOUT_EN
        req_valid = 1'b1;
        req_addr  = 32'h1000_0000;
        sb.push_back(exp_t'{32'h0, 1'b1, cyc + 17});
        step();
        req_valid = 1'b0;
        t_rvalid  = 3'b010;
        for (int i = 0; i < 16; i++) begin
            check("timeout t_valid wait", 32'(t_valid), 32'b010);
            step();
        end
        check("timeout t_valid after", 32'(t_valid), 32'd0);
        step();
        step();
        t_rvalid = 3'b000;
        check("timeout req_ready", 32'(req_ready), 32'd1);
`else
        req_valid = 1'b1;
        req_addr  = 32'h1000_0008;
        sb.push_back(exp_t'{32'h7777_0000, 1'b0, cyc + 23});
        step();
        req_valid = 1'b0;
        acc = cyc;
        for (int i = 0; i < 20; i++) step();
        check("no-timeout t_valid", 32'(t_valid), 32'b010);
        check("no-timeout wait", 32'(cyc - acc), 32'd20);
        t_ready = 3'b010;
        step();
        t_ready  = 3'b000;
        t_rvalid = 3'b010;
        t_rdata  = {32'h0, 32'h7777_0000, 32'h0};
        step();
        t_rvalid = 3'b000;
        step();
`endif

        // reset while waiting in RESP for target 0
        req_valid = 1'b1;
        req_addr  = 32'h0000_0020;
        step();
        req_valid = 1'b0;
        check("rst seq t_valid", 32'(t_valid), 32'b001);
        t_ready = 3'b001;
        step();
        t_ready = 3'b000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-rst req_ready", 32'(req_ready), 32'd1);
        check("mid-rst t_valid", 32'(t_valid), 32'd0);
        check("mid-rst t_addr", t_addr, 32'd0);
        check("mid-rst resp_rdata", resp_rdata, 32'd0);
        t_rvalid = 3'b001;
        t_rdata  = {64'h0, 32'hFEED_FACE};
        step();
        t_rvalid = 3'b000;
        step();
        check("post-rst req_ready", 32'(req_ready), 32'd1);
        check("pending responses", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dbus_demux.md
Name: dbus_demux

Overview:
- Routes one data-bus initiator (CPU load/store port) to one of three targets: data RAM, peripheral block, and timer.
- The target is chosen by address decode.
- The matching response is steered back to the initiator.
- This is the fan-out counterpart of the writeback source-select logic.
- Supports one outstanding transaction at a time, with a registered request path and a registered response path.

Parameters:
- T0_BASE, 32'h0000_0000, base address of target 0 (data RAM)
- T0_MASK, 32'hFFFF_0000, decode mask of target 0; hit when (addr & T0_MASK) == T0_BASE
- T1_BASE, 32'h1000_0000, base address of target 1 (peripherals)
- T1_MASK, 32'hFFFF_F000, decode mask of target 1
- T2_BASE, 32'h2000_0000, base address of target 2 (timer)
- T2_MASK, 32'hFFFF_FF00, decode mask of target 2
- TIMEOUT_CYCLES, 16, cycles allowed in REQ+RESP before forced error (used only when DBUS_TIMEOUT_EN is defined)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  initiator request valid
- req_ready  output  1  demux can accept a request
- req_addr  input  32  byte address
- req_we  input  1  1=write, 0=read
- req_wdata  input  32  write data
- req_wstrb  input  4  byte enables
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  read data, 0 on writes and errors
- resp_err  output  1  response is an error (unmapped address or timeout)
- t_valid  output  3  per-target request valid, one-hot or zero
- t_ready  input  3  per-target request accept
- t_addr  output  32  shared registered address to targets
- t_we  output  1  shared registered write enable
- t_wdata  output  32  shared registered write data
- t_wstrb  output  4  shared registered byte enables
- t_rvalid  input  3  per-target completion strobe (reads and writes)
- t_rdata  input  96  per-target read data; target n uses bits [32n+31:32n]

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; t_valid=0; t_addr, t_we, t_wdata and t_wstrb all 0.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr, we, wdata, wstrb and the decoded select.
  - If any target hits, go to REQ. If none hits, go to DONE with err=1.
  - If several targets hit, the lowest index wins.
- REQ:
  - t_valid[sel]=1 and req_ready=0.
  - On t_ready[sel], go to RESP. t_valid drops in the next cycle.
- RESP:
  - Wait for t_rvalid[sel].
  - On it, capture t_rdata slice sel; reads keep the captured data, writes force it to 0. Go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle, with registered resp_rdata and resp_err. Then return to IDLE.
  - The response has no backpressure; the initiator must take it.
- Minimum latency, mapped target with t_ready and t_rvalid each asserted the first cycle they can be: request accepted at edge N; t_valid high in cycle N+1; RESP in N+2; resp_valid in cycle N+3 when t_rvalid is seen in N+2.
- Unmapped address: resp_valid 1 cycle after acceptance, with resp_err=1 and resp_rdata=0. No t_valid is raised.
- t_ready or t_rvalid from non-selected targets, or outside REQ/RESP, is ignored.
- t_ready and t_rvalid both high in the same REQ cycle: only the ready is honoured. The target must present rvalid again in RESP.
- req_valid while req_ready=0 is not accepted. The initiator holds it and it is accepted on the next IDLE cycle.
- resp_rdata and resp_err hold their value after the resp_valid pulse until the next DONE.
- Reset mid-transaction: next cycle is IDLE and all outputs are at reset values. The in-flight transaction is dropped with no response.

Optional Feature:
- Macro DBUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES, go to DONE with resp_err=1 and resp_rdata=0, and drop t_valid.
  - A later stray t_rvalid is ignored.
- Undefined: no counter is built, REQ/RESP wait indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
- Read 0x0000_0010; target 0 gives t_ready and t_rvalid at first opportunity with rdata 0xCAFEF00D -> t_valid=3'b001 for 1 cycle; resp_valid at acceptance+3 with rdata 0xCAFEF00D, err=0.
- Write 0x1000_0004, wdata 0x12345678, wstrb 4'b0011; target 1 holds t_ready low for 2 cycles -> t_addr, t_wdata and t_wstrb match the request; t_valid=3'b010 for 3 cycles; resp rdata=0, err=0.
- Read 0x3000_0000 (unmapped) -> no t_valid; resp_valid 1 cycle after acceptance with err=1, rdata=0.
- Back-to-back reads to target 2 with req_valid held high -> second request accepted only after DONE; req_ready=0 throughout REQ, RESP and DONE.
- In RESP for target 0, assert rst for 1 cycle, then t_rvalid[0] -> no resp_valid; state IDLE; req_ready=1.
- DBUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, target 1 never raises t_ready -> resp_valid with err=1 exactly 16 cycles after REQ entry; t_valid then 0.
